mul: RTL
========

# mul

Sequential unsigned shift-add multiplier: loads two WIDTH-bit operands on `start`, iterates one multiplier bit per clock, and presents a 2·WIDTH-bit product split into `product_hi`/`product_lo` with a `done` flag. It is the multiply counterpart of the sequential divider in the ALU datapath and shares that block's start/done handshake and hi/lo result split, so the ALU control FSM drives both units the same way.

## Interface
- `WIDTH`, default 32, operand width in bits; the product is 2·WIDTH bits.
- `clk`  in  1  rising-edge clock for all state.
- `reset`  in  1  synchronous, active-high reset, sampled on the `clk` rising edge.
- `start`  in  1  level-sampled load request; takes priority over everything except `reset`.
- `multiplicand`  in  WIDTH  operand A, captured on the `start` edge.
- `multiplier`  in  WIDTH  operand B, captured on the `start` edge.
- `busy`  out  1  high while iterating.
- `done`  out  1  high while the product is valid.
- `product_hi`  out  WIDTH  upper half of the product.
- `product_lo`  out  WIDTH  lower half of the product.

## Operation
- State registers:
  - `m`: WIDTH-bit multiplicand.
  - `acc`: 2·WIDTH-bit accumulator, with `{product_hi, product_lo} = acc`.
  - `count`: ceil(log2(WIDTH+1)) bits.
  - `state` ∈ {IDLE, BUSY, DONE}.
- Priority per edge: `reset` > `start` > iteration.
- `reset`:
  - state=IDLE, acc=0, m=0, count=0.
  - busy=0, done=0, product_hi=0, product_lo=0.
- `start`=1 in any state:
  - m←multiplicand, acc←{WIDTH'b0, multiplier}, count←WIDTH, state←BUSY.
  - Any in-progress operation is abandoned.
- BUSY iteration, one per edge while `start`=0:
  - Form the (WIDTH+1)-bit sum s = acc[hi] + (acc[0] ? m : 0). The carry is kept, not dropped.
  - acc ← {s, acc[lo]} >> 1, a logical shift that brings the carry into the MSB.
  - count ← count−1.
  - When count goes 1→0, state←DONE.
- DONE: acc holds A·B exactly; there is no overflow because the product fits 2·WIDTH bits. The block holds until `start` or `reset`.
- IDLE: holds; outputs reflect acc (0 after reset).
- Outputs:
  - busy = (state==BUSY).
  - done = (state==DONE).
  - Both come directly from registered state; no combinational path from `start`.
- During BUSY, product_hi/lo show intermediate partial products and are not valid.
- Operands are unsigned only. Signed multiply is handled by the ALU wrapper through sign-magnitude correction, outside this block.

## Timing
- Load edge E0 (start=1): busy=1 visible after E0.
- Iterations occur on edges E1..E_WIDTH.
- After E_WIDTH: busy=0, done=1, product valid.
- Latency is WIDTH cycles from the load edge to done, i.e. 32 for the default.
- `start` held high for k cycles: the block reloads on each of those edges and is busy the whole time. Iteration begins on the first edge with start=0. Operands are those present on the last start edge.
- `start` on the same edge that would finish (count 1→0): the reload wins, done stays 0, and a new WIDTH-cycle run begins.
- `reset` mid-BUSY or in DONE: all outputs are 0 after that edge. `reset` together with `start` resolves to reset.
- `done` stays high indefinitely in DONE. Outputs stay stable until the next `start`/`reset` edge.
- Operand inputs are ignored on all edges except `start` edges, so they may change freely during BUSY.

## Test plan
- Reset: hold `reset` for 2 cycles with random inputs, including start=1 → busy=0, done=0, product_hi=0, product_lo=0.
- Basic: start with A=7, B=6 for one cycle → busy for 32 cycles, then done=1, product_hi=0x00000000, product_lo=0x0000002A; stable for 10 further cycles.
- Carry/extremes:
  - A=B=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
  - A=0x80000000, B=2 → hi=0x00000001, lo=0x00000000.
  - A=0, B=0x12345678 → 0.
- Restart mid-run: start A=3, B=5; at iteration 10 pulse start with A=0x10000, B=0x10000 → done exactly 32 cycles after the second start, product hi=0x00000001, lo=0x00000000; done never asserts in between.
- Start held 5 cycles with operands changing each cycle (last pair A=9, B=11) → done 32 cycles after the last start edge, lo=0x63, hi=0.
- Reset mid-run: at iteration 20, assert reset for 1 cycle → outputs 0, state IDLE, no done. A subsequent start with A=0xDEADBEEF, B=1 completes with hi=0, lo=0xDEADBEEF.

Source files
------------

// File: rtl/mul.sv
// Sequential unsigned shift-add multiplier: one multiplier bit per clock,
// start/done handshake and hi/lo product split shared with the divider.
module mul #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] multiplicand,
   input  logic [WIDTH-1:0] multiplier,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] product_hi,
   output logic [WIDTH-1:0] product_lo,
   output logic [1:0]       o_dbg_state   // 0 = idle, 1 = busy, 2 = done
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             r_state, w_state_nxt;
   logic [WIDTH-1:0]   r_m, w_m_nxt;
   logic [2*WIDTH-1:0] r_acc, w_acc_nxt;
   logic [CW-1:0]      r_count, w_count_nxt;
   logic [WIDTH:0]     w_sum;

   // Handshake: start is level-sampled and reloads in any state; busy and
   // done are decoded from registered state only, never from start.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_m     <= '0;
         r_acc   <= '0;
         r_count <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_m     <= w_m_nxt;
         r_acc   <= w_acc_nxt;
         r_count <= w_count_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_m_nxt     = r_m;
      w_acc_nxt   = r_acc;
      w_count_nxt = r_count;
      // Carry out of the upper-half add is kept and shifted into the MSB.
      w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_m} : '0);
      if (start) begin
         w_m_nxt     = multiplicand;
         w_acc_nxt   = {{WIDTH{1'b0}}, multiplier};
         w_count_nxt = CW'(WIDTH);
         w_state_nxt = S_BUSY;
      end else begin
         case (r_state)
            S_BUSY: begin
               w_acc_nxt   = {w_sum, r_acc[WIDTH-1:1]};
               w_count_nxt = r_count - CW'(1);
               if (r_count == CW'(1)) w_state_nxt = S_DONE;
            end
            default: ;
         endcase
      end
   end

   assign busy        = (r_state == S_BUSY);
   assign done        = (r_state == S_DONE);
   assign product_hi  = r_acc[2*WIDTH-1:WIDTH];
   assign product_lo  = r_acc[WIDTH-1:0];
   assign o_dbg_state = r_state;

endmodule
